// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider.
//   DIV_WIDTH     : default operand/result width (matches the 32-bit adder datapath)
//   DIV_CNT_W     : iteration counter width for the default operand width
//   div_state_t   : control FSM states
//   div_cnt_width : counter width needed to count up to a given operand width
package div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    function automatic int div_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int DIV_CNT_W = div_cnt_width(DIV_WIDTH);

endpackage

// File: rtl/restoring_divider_if.sv
// Request/response bundle between a divider user and the restoring divider.
//   in_valid/in_ready   : operand handshake (dividend, divisor)
//   out_valid/out_ready : result handshake (quotient, remainder, div_by_zero)
// master : the user side (drives operands, consumes results)
// slave  : the divider side
interface restoring_divider_if
    import div_pkg::*;
#(
    parameter int W = DIV_WIDTH
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_step.sv
// One radix-2 restoring division iteration, purely combinational.
//   r      : current partial remainder (WIDTH+1 bits)
//   q_msb  : next dividend bit shifted into the remainder
//   d      : divisor
//   r_next : partial remainder after this iteration
//   q_bit  : quotient bit produced by this iteration
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   r,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   r_next,
    output logic             q_bit
);
    logic [WIDTH:0] r_shift;
    logic [WIDTH:0] trial;

    always_comb begin
        r_shift = {r[WIDTH-1:0], q_msb};
        trial   = r_shift - {1'b0, d};
        // A bit carried out of the shift means the shifted remainder is at
        // least 2^WIDTH and therefore always exceeds the divisor. The restoring
        // invariant keeps r[WIDTH] at zero, so this only covers the full form.
        q_bit   = r[WIDTH] | ~trial[WIDTH];
        r_next  = q_bit ? trial : r_shift;
    end
endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned divider: one restoring step per clock.
//   clk   : system clock
//   rst_n : asynchronous active-low reset; aborts any operation in flight
//   bus   : slave side of restoring_divider_if
//           operands accepted on in_valid && in_ready, result presented with
//           out_valid until out_ready. A zero divisor skips iteration and
//           returns quotient = all ones, remainder = dividend, div_by_zero = 1.
module restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    restoring_divider_if.slave   bus
);
    localparam int CNT_W = div_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_t state_reg, state_next;

    // Holds in_ready low through reset and until the first edge after release.
    logic ready_en_reg;

    logic [WIDTH:0]   r_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             div_by_zero_reg;

    logic             in_ready_int;
    logic             out_valid_int;
    logic             accept;
    logic             divisor_zero;

    logic [WIDTH:0]   r_step;
    logic             q_step;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r      (r_reg),
        .q_msb  (q_reg[WIDTH-1]),
        .d      (d_reg),
        .r_next (r_step),
        .q_bit  (q_step)
    );

    assign accept       = bus.in_valid && in_ready_int;
    assign divisor_zero = (bus.divisor == '0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = divisor_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt_reg == LAST_CNT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        in_ready_int  = 1'b0;
        out_valid_int = 1'b0;
        case (state_reg)
            IDLE:    in_ready_int  = ready_en_reg;
            DONE:    out_valid_int = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_reg <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
        end
    end

    // Datapath and result registers. Results load only on the edge that
    // enters DONE, so they stay frozen for the whole DONE period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg           <= '0;
            q_reg           <= '0;
            d_reg           <= '0;
            cnt_reg         <= '0;
            quotient_reg    <= '0;
            remainder_reg   <= '0;
            div_by_zero_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        r_reg   <= '0;
                        q_reg   <= bus.dividend;
                        d_reg   <= bus.divisor;
                        cnt_reg <= '0;
                        if (divisor_zero) begin
                            quotient_reg    <= '1;
                            remainder_reg   <= bus.dividend;
                            div_by_zero_reg <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    r_reg   <= r_step;
                    q_reg   <= {q_reg[WIDTH-2:0], q_step};
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == LAST_CNT) begin
                        quotient_reg    <= {q_reg[WIDTH-2:0], q_step};
                        remainder_reg   <= r_step[WIDTH-1:0];
                        div_by_zero_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = in_ready_int;
    assign bus.out_valid   = out_valid_int;
    assign bus.quotient    = quotient_reg;
    assign bus.remainder   = remainder_reg;
    assign bus.div_by_zero = div_by_zero_reg;

endmodule

// File: tb/tb_restoring_divider.sv
module tb_restoring_divider;
    localparam int W = 32;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_fail;

    restoring_divider_if #(.W(W)) intf ();

    restoring_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (intf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full operation: wait for in_ready, accept, measure latency, check the
    // result, optionally stall out_ready for 'hold' cycles, then handshake.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz,
                          input int elat, input int hold);
        int waited;
        int lat;
        intf.dividend  = a;
        intf.divisor   = b;
        intf.in_valid  = 1'b1;
        intf.out_ready = (hold == 0);
        waited = 0;
        while (!intf.in_ready && waited < 100) begin
            tick();
            waited++;
        end
        chk({tag, " in_ready before accept"}, 64'(intf.in_ready), 64'd1);
        tick();
        intf.in_valid = 1'b0;
        chk({tag, " in_ready after accept"}, 64'(intf.in_ready), 64'd0);
        lat = 1;
        while (!intf.out_valid && lat < 200) begin
            tick();
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'(elat));
        chk({tag, " quotient"}, 64'(intf.quotient), 64'(eq));
        chk({tag, " remainder"}, 64'(intf.remainder), 64'(er));
        chk({tag, " div_by_zero"}, 64'(intf.div_by_zero), 64'(edbz));
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, " hold out_valid"}, 64'(intf.out_valid), 64'd1);
            chk({tag, " hold quotient"}, 64'(intf.quotient), 64'(eq));
            chk({tag, " hold remainder"}, 64'(intf.remainder), 64'(er));
            chk({tag, " hold in_ready"}, 64'(intf.in_ready), 64'd0);
        end
        intf.out_ready = 1'b1;
        tick();
        chk({tag, " out_valid after handshake"}, 64'(intf.out_valid), 64'd0);
        chk({tag, " in_ready after handshake"}, 64'(intf.in_ready), 64'd1);
        $display("op %s: %0d / %0d -> q=0x%0h r=0x%0h dbz=%0d lat=%0d",
                 tag, a, b, intf.quotient, intf.remainder, intf.div_by_zero, lat);
    endtask

    initial begin
        int lat;
        n_checks = 0;
        n_fail   = 0;
        rst_n          = 1'b0;
        intf.in_valid  = 1'b0;
        intf.dividend  = '0;
        intf.divisor   = '0;
        intf.out_ready = 1'b0;

        // Reset state
        #1;
        chk("reset in_ready", 64'(intf.in_ready), 64'd0);
        chk("reset out_valid", 64'(intf.out_valid), 64'd0);
        chk("reset quotient", 64'(intf.quotient), 64'd0);
        chk("reset remainder", 64'(intf.remainder), 64'd0);
        chk("reset div_by_zero", 64'(intf.div_by_zero), 64'd0);
        tick();
        tick();
        chk("reset held in_ready", 64'(intf.in_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("release before edge in_ready", 64'(intf.in_ready), 64'd0);
        tick();
        chk("release after edge in_ready", 64'(intf.in_ready), 64'd1);
        $display("reset released");

        run_op("7/2",        32'd7,          32'd2,          32'd3,          32'd1, 1'b0, 33, 0);
        run_op("max/1",      32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0, 1'b0, 33, 0);
        run_op("max/max",    32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0, 1'b0, 33, 0);
        run_op("5/0",        32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5, 1'b1, 1,  0);
        run_op("10/3",       32'd10,         32'd3,          32'd3,          32'd1, 1'b0, 33, 0);
        run_op("3/7",        32'd3,          32'd7,          32'd0,          32'd3, 1'b0, 33, 0);
        run_op("0/5",        32'd0,          32'd5,          32'd0,          32'd0, 1'b0, 33, 0);
        run_op("100/7 bp",   32'd100,        32'd7,          32'd14,         32'd2, 1'b0, 33, 5);

        // Reset in the middle of a calculation
        intf.dividend  = 32'd1000;
        intf.divisor   = 32'd3;
        intf.in_valid  = 1'b1;
        intf.out_ready = 1'b1;
        tick();
        intf.in_valid = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        chk("midreset out_valid", 64'(intf.out_valid), 64'd0);
        chk("midreset quotient", 64'(intf.quotient), 64'd0);
        chk("midreset remainder", 64'(intf.remainder), 64'd0);
        chk("midreset div_by_zero", 64'(intf.div_by_zero), 64'd0);
        chk("midreset in_ready", 64'(intf.in_ready), 64'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("midreset release in_ready", 64'(intf.in_ready), 64'd0);
        tick();
        chk("midreset post in_ready", 64'(intf.in_ready), 64'd1);
        chk("midreset post out_valid", 64'(intf.out_valid), 64'd0);
        $display("reset pulsed during 1000/3");

        run_op("9/4",        32'd9,          32'd4,          32'd2,          32'd1, 1'b0, 33, 0);

        // Back-to-back with in_valid held high; operand changes during CALC
        // must not disturb the running division.
        intf.dividend  = 32'd20;
        intf.divisor   = 32'd6;
        intf.in_valid  = 1'b1;
        intf.out_ready = 1'b1;
        tick();
        chk("b2b A in_ready after accept", 64'(intf.in_ready), 64'd0);
        intf.dividend = 32'd50;
        intf.divisor  = 32'd5;
        lat = 1;
        while (!intf.out_valid && lat < 200) begin
            tick();
            lat++;
        end
        chk("b2b A latency", 64'(lat), 64'd33);
        chk("b2b A quotient", 64'(intf.quotient), 64'd3);
        chk("b2b A remainder", 64'(intf.remainder), 64'd2);
        $display("op b2b A: 20 / 6 -> q=0x%0h r=0x%0h", intf.quotient, intf.remainder);
        tick();
        chk("b2b A out_valid after handshake", 64'(intf.out_valid), 64'd0);
        chk("b2b A in_ready after handshake", 64'(intf.in_ready), 64'd1);
        tick();
        chk("b2b B in_ready after accept", 64'(intf.in_ready), 64'd0);
        intf.in_valid = 1'b0;
        lat = 1;
        while (!intf.out_valid && lat < 200) begin
            tick();
            lat++;
        end
        chk("b2b B latency", 64'(lat), 64'd33);
        chk("b2b B quotient", 64'(intf.quotient), 64'd10);
        chk("b2b B remainder", 64'(intf.remainder), 64'd0);
        chk("b2b B div_by_zero", 64'(intf.div_by_zero), 64'd0);
        $display("op b2b B: 50 / 5 -> q=0x%0h r=0x%0h", intf.quotient, intf.remainder);
        tick();
        chk("b2b B out_valid after handshake", 64'(intf.out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
